// File: rtl/event_stim_checker.sv
// Stimulus/checker for the three-input event-control blocks: sweeps a/b/c over all
// eight combinations, samples x/y after a settle interval and tallies mismatches.
module event_stim_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       XIn,
    input  logic       YIn,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [7:0] ErrCount,
    output logic [2:0] FirstErrVec,
    output logic       FirstErrValid
);

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} stateT;

    stateT      state;
    stateT      nextState;
    logic [2:0] stimVec;
    logic [7:0] passIdx;
    logic [3:0] settleCnt;
    logic       expX;
    logic       expY;
    logic       mismatch;
    logic       lastVec;
    logic       lastPass;
    logic [7:0] errNext;

    // The driven stimulus is the registered vector itself, so A/B/C always equal {a,b,c} of vec.
    assign A    = stimVec[2];
    assign B    = stimVec[1];
    assign C    = stimVec[0];
    assign Busy = (state == SETTLE) || (state == SAMPLE);

    always_comb begin
        nextState = state;
        expX      = stimVec[2] & stimVec[1] & stimVec[0];
        expY      = stimVec[2] ^ (stimVec[1] | stimVec[0]);
        mismatch  = (XIn != expX) || (YIn != expY);
        lastVec   = (stimVec == 3'd7);
        lastPass  = (passIdx == LAST_PASS);
        errNext   = ErrCount;
        if (state == SAMPLE && mismatch && ErrCount != 8'hFF) begin
            errNext = ErrCount + 8'd1;
        end
        case (state)
            IDLE, DONE: if (Start) nextState = SETTLE;
            SETTLE:     if (settleCnt == LAST_SETTLE) nextState = SAMPLE;
            SAMPLE:     nextState = (lastVec && lastPass) ? DONE : SETTLE;
            default:    nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stimVec       <= 3'd0;
            passIdx       <= 8'd0;
            settleCnt     <= 4'd0;
            Done          <= 1'b0;
            Pass          <= 1'b0;
            ErrCount      <= 8'd0;
            FirstErrVec   <= 3'd0;
            FirstErrValid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        stimVec       <= 3'd0;
                        passIdx       <= 8'd0;
                        settleCnt     <= 4'd0;
                        ErrCount      <= 8'd0;
                        FirstErrVec   <= 3'd0;
                        FirstErrValid <= 1'b0;
                        Done          <= 1'b0;
                    end
                end
                SETTLE: settleCnt <= settleCnt + 4'd1;
                SAMPLE: begin
                    ErrCount  <= errNext;
                    settleCnt <= 4'd0;
                    if (mismatch && !FirstErrValid) begin
                        FirstErrVec   <= stimVec;
                        FirstErrValid <= 1'b1;
                    end
                    // Pass reflects the count including the final sample of the run.
                    if (!lastVec) begin
                        stimVec <= stimVec + 3'd1;
                    end else if (!lastPass) begin
                        passIdx <= passIdx + 8'd1;
                        stimVec <= 3'd0;
                    end else begin
                        Done <= 1'b1;
                        Pass <= (errNext == 8'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_event_stim_checker.sv
// Scoreboard bench: three checker instances with different settle/pass settings, each
// fed by a reference x/y model with selectable faults.
module tb_event_stim_checker;

    typedef struct {
        int id;
        int doneCyc;
        int err;
        int fv;
        int fvv;
        int ps;
    } expT;

    logic       Clk;
    logic       Reset;
    logic [2:0] startV;
    int         faultMode;
    int         cyc = 0;
    int         passCnt = 0;
    int         totalCnt = 0;
    expT        sbq[$];
    expT        monE;
    logic       doneD[3];

    logic       aS[3], bS[3], cS[3], xS[3], yS[3];
    logic       busyS[3], doneS[3], passS[3], fvvS[3];
    logic [7:0] errS[3];
    logic [2:0] fvS[3];

    for (genvar g = 0; g < 3; g++) begin : gDut
        logic ex, ey;
        assign ex    = aS[g] & bS[g] & cS[g];
        assign ey    = aS[g] ^ (bS[g] | cS[g]);
        assign xS[g] = (faultMode == 1) ? 1'b0 : ((faultMode == 3) ? ~ex : ex);
        assign yS[g] = (faultMode == 2 || faultMode == 3) ? ~ey : ey;
        event_stim_checker #(
            .SETTLE_CYCLES(g == 2 ? 1 : 2),
            .PASSES(g == 0 ? 1 : (g == 1 ? 2 : 40))
        ) u (
            .Clk(Clk), .Reset(Reset), .Start(startV[g]),
            .XIn(xS[g]), .YIn(yS[g]),
            .A(aS[g]), .B(bS[g]), .C(cS[g]),
            .Busy(busyS[g]), .Done(doneS[g]), .Pass(passS[g]),
            .ErrCount(errS[g]), .FirstErrVec(fvS[g]), .FirstErrValid(fvvS[g])
        );
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic startRun(input int id, input bit push, input int err, input int fv,
                            input int fvv, input int ps, input int lat);
        expT e;
        @(negedge Clk);
        startV[id] = 1'b1;
        if (push) begin
            e.id = id; e.doneCyc = cyc + 1 + lat;
            e.err = err; e.fv = fv; e.fvv = fvv; e.ps = ps;
            sbq.push_back(e);
        end
        @(negedge Clk);
        startV[id] = 1'b0;
    endtask

    task automatic waitDone(input int id, input int budget);
        for (int i = 0; i < budget && !doneS[id]; i++) @(negedge Clk);
        chk("done_timeout", int'(doneS[id]), 1);
    endtask

    // Monitor: every rising Done retires one expected result from the scoreboard.
    always @(negedge Clk) begin
        for (int d = 0; d < 3; d++) begin
            if (doneS[d] && !doneD[d]) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_done", d, -1);
                end else begin
                    monE = sbq.pop_front();
                    chk("sb_id", d, monE.id);
                    chk("sb_done_edge", cyc, monE.doneCyc);
                    chk("sb_errcount", int'(errS[d]), monE.err);
                    chk("sb_firstvec", int'(fvS[d]), monE.fv);
                    chk("sb_firstvalid", int'(fvvS[d]), monE.fvv);
                    chk("sb_pass", int'(passS[d]), monE.ps);
                    chk("sb_abc_done", int'({aS[d], bS[d], cS[d]}), 7);
                    chk("sb_busy_done", int'(busyS[d]), 0);
                end
            end
            doneD[d] = doneS[d];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got %0d want 0", 1);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        startV    = 3'b000;
        faultMode = 0;
        for (int d = 0; d < 3; d++) doneD[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_abc", int'({aS[d], bS[d], cS[d]}), 0);
            chk("rst_busy_done", int'({busyS[d], doneS[d], passS[d]}), 0);
            chk("rst_err", int'({errS[d], fvS[d], fvvS[d]}), 0);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Clean sweep: stepping every three cycles, Done 24 edges after Start.
        startRun(0, 1'b1, 0, 0, 0, 1, 24);
        for (int n = 0; n < 24; n++) begin
            chk("t1_abc", int'({aS[0], bS[0], cS[0]}), (n / 3) % 8);
            chk("t1_busy", int'(busyS[0]), 1);
            @(negedge Clk);
        end
        waitDone(0, 50);

        // x stuck low: only vector 111 fails.
        faultMode = 1;
        startRun(0, 1'b1, 1, 7, 1, 0, 24);
        waitDone(0, 50);

        // y inverted over two passes.
        faultMode = 2;
        startRun(1, 1'b1, 16, 0, 1, 0, 48);
        waitDone(1, 100);

        // Both wrong on every vector, 320 errors saturate at 255.
        faultMode = 3;
        startRun(2, 1'b1, 255, 0, 1, 0, 640);
        waitDone(2, 1000);

        // Asynchronous reset in the middle of vector 4's settle interval.
        faultMode = 3;
        startRun(0, 1'b0, 0, 0, 0, 0, 0);
        repeat (13) @(negedge Clk);
        chk("t5_abc_before", int'({aS[0], bS[0], cS[0]}), 4);
        chk("t5_err_before", int'(errS[0]), 4);
        #1 Reset = 1'b1;
        #1;
        chk("t5_abc_rst", int'({aS[0], bS[0], cS[0]}), 0);
        chk("t5_busy_rst", int'(busyS[0]), 0);
        chk("t5_err_rst", int'(errS[0]), 0);
        chk("t5_fvv_rst", int'(fvvS[0]), 0);
        @(negedge Clk);
        Reset     = 1'b0;
        faultMode = 0;
        startRun(0, 1'b1, 0, 0, 0, 1, 24);
        waitDone(0, 50);

        // Start pulses during a run are ignored; Start in DONE restarts cleanly.
        faultMode = 1;
        startRun(0, 1'b1, 1, 7, 1, 0, 24);
        repeat (4) @(negedge Clk);
        startV[0] = 1'b1;
        @(negedge Clk);
        startV[0] = 1'b0;
        repeat (4) @(negedge Clk);
        startV[0] = 1'b1;
        @(negedge Clk);
        startV[0] = 1'b0;
        waitDone(0, 50);
        faultMode = 0;
        startRun(0, 1'b1, 0, 0, 0, 1, 24);
        chk("t6_done_drop", int'(doneS[0]), 0);
        chk("t6_err_clear", int'(errS[0]), 0);
        chk("t6_fvv_clear", int'(fvvS[0]), 0);
        chk("t6_abc_restart", int'({aS[0], bS[0], cS[0]}), 0);
        chk("t6_busy_restart", int'(busyS[0]), 1);
        waitDone(0, 50);

        repeat (2) @(negedge Clk);
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
